// File: rtl/ahb_bus_arbiter.sv
// Round-robin AHB-Lite bus arbiter with hold timeout and burst-boundary handover.
// Optional locked-sequence support is enabled by defining AHB_ARB_HMASTLOCK_EN.
module ahb_bus_arbiter #(
  parameter int unsigned NM      = 4,
  parameter int unsigned NM_W    = 2,
  parameter int unsigned TIMEOUT = 16
) (
  input  logic            hclk,
  input  logic            hresetn,
  input  logic [NM-1:0]   hbusreq,
  input  logic [NM-1:0]   hlock,
  input  logic [1:0]      htrans,
  input  logic            hready,
  output logic [NM-1:0]   hgrant,
  output logic [NM_W-1:0] hmaster,
  output logic            hmastlock,
  output logic            arb_busy
);

  localparam int unsigned HC_W = $clog2(TIMEOUT + 1);
  localparam logic [1:0]  HTRANS_SEQ = 2'b11;

  typedef enum logic [1:0] {
    PARK   = 2'd0,
    OWN    = 2'd1,
    SWITCH = 2'd2
  } state_t;

  state_t          state_q, state_d;
  logic [NM_W-1:0] owner_q, owner_d;
  logic [HC_W-1:0] hold_q, hold_d;
  logic [HC_W:0]   hold_inc;
  logic [NM_W-1:0] rr_start;
  logic [NM_W-1:0] pick_rr;
  logic [NM_W-1:0] pick_park;
  logic            any_req;
  logic            others_req;
  logic            lock_hold;

  // First set request bit searching upward from start, wrapping; start itself is checked first.
  function automatic logic [NM_W-1:0] rr_pick(input logic [NM-1:0] req, input logic [NM_W-1:0] start);
    logic        found;
    int unsigned idx;
    rr_pick = '0;
    found   = 1'b0;
    for (int unsigned i = 0; i < NM; i++) begin
      idx = (int'(start) + i) % NM;
      if (!found && req[idx]) begin
        rr_pick = NM_W'(idx);
        found   = 1'b1;
      end
    end
  endfunction

  function automatic logic [NM-1:0] to_onehot(input logic [NM_W-1:0] idx);
    to_onehot      = '0;
    to_onehot[idx] = 1'b1;
  endfunction

  // The owner is placed last in the search by starting just after it.
  assign rr_start   = (owner_q == NM_W'(NM - 1)) ? '0 : owner_q + NM_W'(1);
  assign pick_rr    = rr_pick(hbusreq, rr_start);
  assign pick_park  = rr_pick(hbusreq, '0);
  assign any_req    = |hbusreq;
  assign others_req = |(hbusreq & ~hgrant);
  assign hold_inc   = {1'b0, hold_q} + (HC_W + 1)'(1);

`ifdef AHB_ARB_HMASTLOCK_EN
  assign lock_hold = hlock[owner_q] & hbusreq[owner_q];
`else
  logic unused_hlock;
  assign unused_hlock = ^hlock;
  assign lock_hold    = 1'b0;
`endif

  // Next-state, next-owner and hold counter.
  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    hold_d  = hold_q;
    case (state_q)
      PARK: begin
        owner_d = '0;
        hold_d  = '0;
        if (any_req) begin
          owner_d = pick_park;
          state_d = OWN;
        end
      end
      OWN: begin
        if (!any_req) begin
          owner_d = '0;
          hold_d  = '0;
          state_d = PARK;
        end else if (!hbusreq[owner_q]) begin
          owner_d = pick_rr;
          hold_d  = '0;
        end else if (lock_hold) begin
          hold_d = hold_q;
        end else if (!others_req) begin
          hold_d = '0;
        end else if (hold_inc >= (HC_W + 1)'(TIMEOUT)) begin
          hold_d  = HC_W'(TIMEOUT);
          state_d = SWITCH;
        end else begin
          hold_d = hold_inc[HC_W-1:0];
        end
      end
      SWITCH: begin
        if (!any_req) begin
          owner_d = '0;
          hold_d  = '0;
          state_d = PARK;
        end else if (!hbusreq[owner_q] || (htrans != HTRANS_SEQ)) begin
          owner_d = pick_rr;
          hold_d  = '0;
          state_d = OWN;
        end
      end
      default: begin
        owner_d = '0;
        hold_d  = '0;
        state_d = PARK;
      end
    endcase
  end

  // All arbitration state advances only on ready cycles.
  always_ff @(posedge hclk or negedge hresetn) begin
    if (!hresetn) begin
      state_q   <= PARK;
      owner_q   <= '0;
      hold_q    <= '0;
      hgrant    <= NM'(1);
      hmaster   <= '0;
      hmastlock <= 1'b0;
    end else if (hready) begin
      state_q <= state_d;
      owner_q <= owner_d;
      hold_q  <= hold_d;
      hgrant  <= to_onehot(owner_d);
      hmaster <= owner_q;
`ifdef AHB_ARB_HMASTLOCK_EN
      hmastlock <= hlock[owner_q];
`else
      hmastlock <= 1'b0;
`endif
    end
  end

  assign arb_busy = hresetn & (any_req | (state_q != PARK));

endmodule

// File: tb/tb_ahb_bus_arbiter.sv
// Self-checking bench for ahb_bus_arbiter (NM=4, TIMEOUT=4): vector table, rotation, lock scenario.
module tb_ahb_bus_arbiter;

  logic       hclk = 1'b0;
  logic       hresetn = 1'b1;
  logic [3:0] hbusreq = '0;
  logic [3:0] hlock = '0;
  logic [1:0] htrans = '0;
  logic       hready = 1'b1;
  logic [3:0] hgrant;
  logic [1:0] hmaster;
  logic       hmastlock;
  logic       arb_busy;

  int errors = 0;
  int checks = 0;

  ahb_bus_arbiter #(.NM(4), .NM_W(2), .TIMEOUT(4)) dut (
    .hclk      (hclk),
    .hresetn   (hresetn),
    .hbusreq   (hbusreq),
    .hlock     (hlock),
    .htrans    (htrans),
    .hready    (hready),
    .hgrant    (hgrant),
    .hmaster   (hmaster),
    .hmastlock (hmastlock),
    .arb_busy  (arb_busy)
  );

  always #5 hclk = ~hclk;

  typedef struct {
    logic [3:0] req;
    logic [1:0] trans;
    logic       rdy;
    logic [3:0] g;
    logic [1:0] m;
    logic       busy;
  } vec_t;

  typedef struct {
    logic [3:0] g;
    logic [1:0] m;
    logic       ml;
    logic       busy;
    string      name;
  } exp_t;

  vec_t tbl[23];
  exp_t sb[$];

  task automatic cmp(input string nm, input logic [7:0] act, input logic [7:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, expv);
    end
  endtask

  task automatic check_pop();
    exp_t e;
    if (sb.size() == 0) begin
      errors++;
      $display("FAIL scoreboard: empty queue got 0 entries expected 1");
    end else begin
      e = sb.pop_front();
      cmp({e.name, " hgrant"},    8'(hgrant),    8'(e.g));
      cmp({e.name, " hmaster"},   8'(hmaster),   8'(e.m));
      cmp({e.name, " hmastlock"}, 8'(hmastlock), 8'(e.ml));
      cmp({e.name, " arb_busy"},  8'(arb_busy),  8'(e.busy));
    end
  endtask

  task automatic step(input logic [3:0] req, input logic [3:0] lk, input logic [1:0] tr,
                      input logic rdy, input logic [3:0] eg, input logic [1:0] em,
                      input logic eml, input logic eb, input string nm);
    exp_t e;
    @(negedge hclk);
    hbusreq = req;
    hlock   = lk;
    htrans  = tr;
    hready  = rdy;
    e = '{g: eg, m: em, ml: eml, busy: eb, name: nm};
    sb.push_back(e);
    @(posedge hclk);
    #1;
    check_pop();
  endtask

  // Expected owner during 4-master rotation after k ready edges (4 own + 1 switch cycle each).
  function automatic int rot_idx(input int k);
    if (k < 6) return 0;
    return (1 + (k - 6) / 5) % 4;
  endfunction

  // Expected owner in the lock scenario when locking is not honoured.
  function automatic int lk_idx(input int k);
`ifdef AHB_ARB_HMASTLOCK_EN
    if (k == 0) return 0;
    return 2;
`else
    if (k == 0) return 0;
    if (k <= 5) return 2;
    if (k <= 10) return 0;
    return 2;
`endif
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int r;
    logic rdy;
    logic [3:0] eg;
    logic eml;

    tbl[0]  = '{4'b0000, 2'b00, 1'b1, 4'b0001, 2'd0, 1'b0};
    tbl[1]  = '{4'b0110, 2'b00, 1'b1, 4'b0010, 2'd0, 1'b1};
    tbl[2]  = '{4'b0110, 2'b00, 1'b1, 4'b0010, 2'd1, 1'b1};
    tbl[3]  = '{4'b0100, 2'b11, 1'b1, 4'b0100, 2'd1, 1'b1};
    tbl[4]  = '{4'b0100, 2'b00, 1'b1, 4'b0100, 2'd2, 1'b1};
    tbl[5]  = '{4'b0000, 2'b00, 1'b1, 4'b0001, 2'd2, 1'b0};
    tbl[6]  = '{4'b0000, 2'b00, 1'b1, 4'b0001, 2'd0, 1'b0};
    tbl[7]  = '{4'b1000, 2'b00, 1'b0, 4'b0001, 2'd0, 1'b1};
    tbl[8]  = '{4'b1000, 2'b00, 1'b1, 4'b1000, 2'd0, 1'b1};
    tbl[9]  = '{4'b1000, 2'b00, 1'b1, 4'b1000, 2'd3, 1'b1};
    tbl[10] = '{4'b0011, 2'b10, 1'b1, 4'b0001, 2'd3, 1'b1};
    tbl[11] = '{4'b0011, 2'b10, 1'b1, 4'b0001, 2'd0, 1'b1};
    tbl[12] = '{4'b0010, 2'b10, 1'b1, 4'b0010, 2'd0, 1'b1};
    tbl[13] = '{4'b0011, 2'b10, 1'b1, 4'b0010, 2'd1, 1'b1};
    tbl[14] = '{4'b0011, 2'b10, 1'b1, 4'b0010, 2'd1, 1'b1};
    tbl[15] = '{4'b0011, 2'b10, 1'b1, 4'b0010, 2'd1, 1'b1};
    tbl[16] = '{4'b0011, 2'b10, 1'b1, 4'b0010, 2'd1, 1'b1};
    tbl[17] = '{4'b0011, 2'b11, 1'b1, 4'b0010, 2'd1, 1'b1};
    tbl[18] = '{4'b0011, 2'b11, 1'b1, 4'b0010, 2'd1, 1'b1};
    tbl[19] = '{4'b0011, 2'b11, 1'b1, 4'b0010, 2'd1, 1'b1};
    tbl[20] = '{4'b0011, 2'b10, 1'b1, 4'b0001, 2'd1, 1'b1};
    tbl[21] = '{4'b0011, 2'b10, 1'b1, 4'b0001, 2'd0, 1'b1};
    tbl[22] = '{4'b0000, 2'b00, 1'b1, 4'b0001, 2'd0, 1'b0};

    // Asynchronous reset before any clock edge
    #2 hresetn = 1'b0;
    #1;
    cmp("reset hgrant",    8'(hgrant),    8'h01);
    cmp("reset hmaster",   8'(hmaster),   8'h00);
    cmp("reset hmastlock", 8'(hmastlock), 8'h00);
    cmp("reset arb_busy",  8'(arb_busy),  8'h00);
    repeat (2) @(negedge hclk);
    hresetn = 1'b1;

    // Basic grant, owner drop, park, stall and burst-boundary handover vectors
    foreach (tbl[i])
      step(tbl[i].req, 4'b0000, tbl[i].trans, tbl[i].rdy, tbl[i].g, tbl[i].m, 1'b0, tbl[i].busy,
           $sformatf("vec%0d", i));

    // Four-way rotation with ready stalls mid-hold and at a handover
    r = 0;
    for (int s = 0; s < 40; s++) begin
      rdy = !(s == 3 || s == 4 || s == 12 || s == 13 || s == 14);
      if (rdy) r++;
      eg = 4'(1 << rot_idx(r));
      step(4'b1111, 4'b0000, 2'b10, rdy, eg, (r == 0) ? 2'd0 : 2'(rot_idx(r - 1)), 1'b0, 1'b1,
           $sformatf("rot%0d", s));
    end

    // Return to park
    step(4'b0000, 4'b0000, 2'b00, 1'b1, 4'b0001, 2'(rot_idx(r)), 1'b0, 1'b0, "park0");
    step(4'b0000, 4'b0000, 2'b00, 1'b1, 4'b0001, 2'd0, 1'b0, 1'b0, "park1");

    // Locked owner 2 against a competing master 0
    for (int k = 1; k <= 13; k++) begin
`ifdef AHB_ARB_HMASTLOCK_EN
      eml = (k >= 2);
`else
      eml = 1'b0;
`endif
      step((k == 1) ? 4'b0100 : 4'b0101, 4'b0100, 2'b10, 1'b1, 4'(1 << lk_idx(k)),
           2'(lk_idx(k - 1)), eml, 1'b1, $sformatf("lock%0d", k));
    end

    // Reset asserted mid-cycle with requests active
    @(negedge hclk);
    #2 hresetn = 1'b0;
    #1;
    cmp("midreset hgrant",    8'(hgrant),    8'h01);
    cmp("midreset hmaster",   8'(hmaster),   8'h00);
    cmp("midreset hmastlock", 8'(hmastlock), 8'h00);
    cmp("midreset arb_busy",  8'(arb_busy),  8'h00);
    cmp("scoreboard drained", 8'(sb.size()), 8'h00);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
